// File: rtl/sll_iter_shift_pkg.sv
// Shared definitions for the iterative ALU shift units: FSM encodings,
// shift-amount width and the legal per-cycle step sizes.
package sll_iter_shift_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  localparam int SHAMT_W = 4;

  localparam int STEP_1 = 1;
  localparam int STEP_2 = 2;
  localparam int STEP_4 = 4;
  localparam int STEP_8 = 8;

endpackage

// File: rtl/sll_iter_shift_step.sv
// One iteration of the left shifter: shifts acc by min(rem, STEP) with zero fill
// and returns the reduced remaining count. Purely combinational.
module sll_step
  import sll_iter_shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 4
) (
  input  logic [WIDTH-1:0]   acc,
  input  logic [SHAMT_W-1:0] rem,
  output logic [WIDTH-1:0]   acc_next,
  output logic [SHAMT_W-1:0] rem_next
);

  // Step never exceeds STEP, so it fits in clog2(STEP)+1 bits.
  localparam int NSTG = $clog2(STEP) + 1;
  localparam logic [SHAMT_W-1:0] STEP_C = SHAMT_W'(STEP);

  logic [NSTG-1:0]            step;
  logic [NSTG:0][WIDTH-1:0]   stg;

  assign step   = (rem > STEP_C) ? NSTG'(STEP) : rem[NSTG-1:0];
  assign stg[0] = acc;

  // Binary-weighted mux stages: stage gi shifts by 2**gi when that step bit is set.
  for (genvar gi = 0; gi < NSTG; gi++) begin : g_stage
    assign stg[gi+1] = step[gi] ? (stg[gi] << (1 << gi)) : stg[gi];
  end

  assign acc_next = stg[NSTG];
  assign rem_next = rem - SHAMT_W'(step);

endmodule

// File: rtl/sll_iter_shift.sv
// Iterative logical-left shifter: FSM, accumulator/remaining-count registers,
// held result register and zero flag.
module sll_iter_shift
  import sll_iter_shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   In,
  input  logic [3:0]         Value,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   Out,
  output logic               flag_z
);

  localparam logic [SHAMT_W-1:0] STEP_C = SHAMT_W'(STEP);

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     acc_reg;
  logic [SHAMT_W-1:0]   rem_reg;
  logic [WIDTH-1:0]     out_reg;
  logic [WIDTH-1:0]     acc_step;
  logic [SHAMT_W-1:0]   rem_step;
  logic                 last_step;

  sll_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .acc      (acc_reg),
    .rem      (rem_reg),
    .acc_next (acc_step),
    .rem_next (rem_step)
  );

  assign last_step = (rem_reg <= STEP_C);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_SHIFT;
      S_SHIFT: if (last_step) state_next = S_DONE;
      S_DONE:  state_next = start ? S_SHIFT : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // The visible result lives in out_reg so Out stays frozen while acc is shifting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      acc_reg   <= '0;
      rem_reg   <= '0;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start) begin
            acc_reg <= In;
            rem_reg <= Value;
          end
        end
        S_SHIFT: begin
          acc_reg <= acc_step;
          rem_reg <= rem_step;
          if (last_step) out_reg <= acc_step;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state_reg == S_SHIFT);
  assign done   = (state_reg == S_DONE);
  assign Out    = out_reg;
  assign flag_z = (out_reg == '0);

endmodule

// File: tb/tb_sll_iter_shift.sv
// Bench for sll_iter_shift: four instances (STEP 1, 2, 4, 8) driven in parallel;
// directed table, hand-written corner sequences and a Value sweep.
module tb_sll_iter_shift;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] in_d;
  logic [3:0]  val_d;
  logic        busy_w [4];
  logic        done_w [4];
  logic [15:0] out_w  [4];
  logic        z_w    [4];

  int checks;
  int failures;

  int          got_lat  [4];
  int          nbusy    [4];
  int          ndone    [4];
  logic [15:0] got_out  [4];
  logic        got_z    [4];

  typedef struct {
    logic [15:0] a;
    logic [3:0]  v;
    logic [15:0] exp_out;
    logic        exp_z;
    int          exp_lat4;
  } vec_t;

  vec_t tbl [8];

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    sll_iter_shift #(
      .WIDTH (16),
      .STEP  (1 << gi)
    ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .In     (in_d),
      .Value  (val_d),
      .busy   (busy_w[gi]),
      .done   (done_w[gi]),
      .Out    (out_w[gi]),
      .flag_z (z_w[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish (actual running, required finished)");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  // Launch one op on all instances and observe 18 cycles from the accepting edge.
  task automatic run_op(input logic [15:0] a, input logic [3:0] v);
    @(posedge clk); #1;
    start = 1'b1; in_d = a; val_d = v;
    for (int k = 0; k < 4; k++) begin
      got_lat[k] = -1; nbusy[k] = 0; ndone[k] = 0;
      got_out[k] = '0; got_z[k] = 1'b0;
    end
    for (int c = 0; c < 18; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        start = 1'b0; in_d = 16'($urandom); val_d = 4'($urandom);
      end
      for (int k = 0; k < 4; k++) begin
        if (busy_w[k]) nbusy[k]++;
        if (done_w[k]) begin
          ndone[k]++;
          if (got_lat[k] < 0) begin
            got_lat[k] = c; got_out[k] = out_w[k]; got_z[k] = z_w[k];
          end
        end
      end
    end
  endtask

  task automatic check_model(input logic [15:0] a, input logic [3:0] v);
    logic [15:0] exp;
    int step, lat;
    exp = a << v;
    for (int k = 0; k < 4; k++) begin
      step = 1 << k;
      lat  = (v == 0) ? 1 : (int'(v) + step - 1) / step;
      chk($sformatf("lat s%0d a%h v%0d", step, a, v), got_lat[k], lat);
      chk($sformatf("busy s%0d a%h v%0d", step, a, v), nbusy[k], lat);
      chk($sformatf("ndone s%0d a%h v%0d", step, a, v), ndone[k], 1);
      chk($sformatf("out s%0d a%h v%0d", step, a, v), got_out[k], exp);
      chk($sformatf("z s%0d a%h v%0d", step, a, v), got_z[k], exp == 16'h0);
    end
  endtask

  initial begin
    logic [15:0] r;
    checks = 0; failures = 0;
    start = 1'b0; in_d = '0; val_d = '0; rst = 1'b1;

    tbl[0] = '{16'h0001, 4'd15, 16'h8000, 1'b0, 4};
    tbl[1] = '{16'hA5A5, 4'd0,  16'hA5A5, 1'b0, 1};
    tbl[2] = '{16'h8001, 4'd1,  16'h0002, 1'b0, 1};
    tbl[3] = '{16'hF000, 4'd4,  16'h0000, 1'b1, 1};
    tbl[4] = '{16'h0003, 4'd2,  16'h000C, 1'b0, 1};
    tbl[5] = '{16'h1234, 4'd12, 16'h4000, 1'b0, 3};
    tbl[6] = '{16'h00FF, 4'd8,  16'hFF00, 1'b0, 2};
    tbl[7] = '{16'hFFFF, 4'd5,  16'hFFE0, 1'b0, 2};

    // Reset held for two cycles.
    wait_cycles(2);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst busy s%0d", 1 << k), busy_w[k], 0);
      chk($sformatf("rst done s%0d", 1 << k), done_w[k], 0);
      chk($sformatf("rst out s%0d", 1 << k), out_w[k], 16'h0000);
      chk($sformatf("rst z s%0d", 1 << k), z_w[k], 1);
    end
    rst = 1'b0;

    // Directed table: hand values against the STEP=4 instance, model for all.
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].v);
      chk($sformatf("tbl%0d out", i), got_out[2], tbl[i].exp_out);
      chk($sformatf("tbl%0d z", i), got_z[2], tbl[i].exp_z);
      chk($sformatf("tbl%0d lat", i), got_lat[2], tbl[i].exp_lat4);
      check_model(tbl[i].a, tbl[i].v);
    end

    // start/In/Value toggled while in SHIFT must not disturb the result.
    @(posedge clk); #1;
    start = 1'b1; in_d = 16'h1234; val_d = 4'd12;
    @(posedge clk); #1;
    start = 1'b1; in_d = 16'hFFFF; val_d = 4'd1;
    @(posedge clk); #1;
    start = 1'b0; in_d = 16'h0F0F;
    chk("tog busy c1", busy_w[2], 1);
    @(posedge clk); #1;
    chk("tog busy c2", busy_w[2], 1);
    chk("tog out frozen", out_w[2], 16'hFFE0);
    @(posedge clk); #1;
    chk("tog done", done_w[2], 1);
    chk("tog out", out_w[2], 16'h4000);
    @(posedge clk); #1;
    chk("tog done pulse", done_w[2], 0);
    chk("tog out hold", out_w[2], 16'h4000);
    wait_cycles(20);

    // Back-to-back: start held through DONE reloads with no IDLE cycle.
    @(posedge clk); #1;
    start = 1'b1; in_d = 16'h0001; val_d = 4'd4;
    @(posedge clk); #1;
    in_d = 16'h0003; val_d = 4'd2;
    @(posedge clk); #1;
    chk("b2b done1", done_w[2], 1);
    chk("b2b out1", out_w[2], 16'h0010);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b busy", busy_w[2], 1);
    chk("b2b done gap", done_w[2], 0);
    @(posedge clk); #1;
    chk("b2b done2", done_w[2], 1);
    chk("b2b out2", out_w[2], 16'h000C);
    chk("b2b z2", z_w[2], 0);
    @(posedge clk); #1;
    chk("b2b idle", done_w[2] | busy_w[2], 0);
    wait_cycles(20);

    // Reset mid-SHIFT aborts; no done pulse follows.
    @(posedge clk); #1;
    start = 1'b1; in_d = 16'h1234; val_d = 4'd12;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("abort busy pre", busy_w[2], 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("abort busy s%0d", 1 << k), busy_w[k], 0);
      chk($sformatf("abort out s%0d", 1 << k), out_w[k], 16'h0000);
      chk($sformatf("abort z s%0d", 1 << k), z_w[k], 1);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("abort nodone c%0d", c), done_w[2], 0);
    end
    run_op(16'h1234, 4'd12);
    check_model(16'h1234, 4'd12);

    // Sweep every Value with random operands on all four step sizes.
    for (int v = 0; v < 16; v++) begin
      for (int j = 0; j < 3; j++) begin
        r = 16'($urandom);
        run_op(r, 4'(v));
        check_model(r, 4'(v));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
